// File: rtl/aes_round_ctrl_if.sv
// Request, datapath-control and result handshake between the AES round
// controller (slave) and its requester / datapath (master).
interface aes_round_ctrl_if;
    logic       key_valid;
    logic       start_valid;
    logic       start_ready;
    logic       mode;
    logic [1:0] op;
    logic       state_en;
    logic [3:0] round_idx;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       mode_q;

    modport master (
        output key_valid, start_valid, mode, out_ready,
        input  start_ready, op, state_en, round_idx, out_valid, busy, mode_q
    );

    modport slave (
        input  key_valid, start_valid, mode, out_ready,
        output start_ready, op, state_en, round_idx, out_valid, busy, mode_q
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES round datapath: steps key slot, op select
// and state-register enable for one block, then holds it until consumed.
module aes_round_ctrl #(
    parameter int nk = 4,
    parameter int nr = 10
) (
    input logic             clk,
    input logic             rst_n,
    aes_round_ctrl_if.slave bus
);
    if (!((nk == 4 || nk == 6 || nk == 8) && nr == nk + 6)) begin : g_bad_param
        $error("aes_round_ctrl: nk must be 4/6/8 and nr must be nk+6");
    end

    localparam logic [3:0] NR = 4'(nr);

    typedef enum logic [2:0] {IDLE, INIT, ROUND, LAST, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] r, r_nxt;
    logic       mode_r, mode_nxt;
    logic [1:0] op;
    logic [3:0] idx;
    logic       state_en, start_ready, out_valid, busy, kv, accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            r      <= '0;
            mode_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            r      <= r_nxt;
            mode_r <= mode_nxt;
        end
    end

    // A key stall simply withholds state_en and every transition, so the
    // current round repeats its control word until the schedule is back.
    always_comb begin
        state_nxt   = state;
        r_nxt       = r;
        mode_nxt    = mode_r;
        op          = 2'b00;
        idx         = 4'd0;
        state_en    = 1'b0;
        start_ready = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        kv          = bus.key_valid;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                start_ready = kv;
                accept      = bus.start_valid & kv;
                state_en    = accept;
                busy        = accept;
                if (accept) begin
                    mode_nxt  = bus.mode;
                    r_nxt     = 4'd1;
                    state_nxt = INIT;
                end
            end
            INIT: begin
                op       = 2'b01;
                idx      = mode_r ? NR : 4'd0;
                state_en = kv;
                if (kv) state_nxt = ROUND;
            end
            ROUND: begin
                op       = 2'b10;
                idx      = mode_r ? NR - r : r;
                state_en = kv;
                if (kv) begin
                    if (r == NR - 4'd1) state_nxt = LAST;
                    else                r_nxt     = r + 4'd1;
                end
            end
            LAST: begin
                op       = 2'b11;
                idx      = mode_r ? 4'd0 : NR;
                state_en = kv;
                if (kv) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                    r_nxt     = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.op          = op;
    assign bus.round_idx   = idx;
    assign bus.state_en    = state_en;
    assign bus.start_ready = start_ready;
    assign bus.out_valid   = out_valid;
    assign bus.busy        = busy;
    assign bus.mode_q      = mode_r;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench: two controllers (AES-128 and AES-256) each drive a
// behavioral AES datapath; results are compared with FIPS-197 vectors.
module tb_aes_round_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc, prev_acc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_round_ctrl_if ifa ();
    aes_round_ctrl_if ifb ();

    aes_round_ctrl #(.nk(4), .nr(10)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    aes_round_ctrl #(.nk(8), .nr(14)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K256  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic [7:0]    sb [256];
    logic [7:0]    isb[256];
    logic [2047:0] ks_a, ks_b;
    logic [127:0]  din_a, din_b, st_a, st_b;
    logic [7:0]    iv, bx;
    logic          saw_ov;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00; aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [127:0] sub(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? isb[s[127-8*i -: 8]] : sb[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (!inv) o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
                else      o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   m [4];
        logic [7:0]   b;
        m[0] = inv ? 8'h0e : 8'h02; m[1] = inv ? 8'h0b : 8'h03;
        m[2] = inv ? 8'h0d : 8'h01; m[3] = inv ? 8'h09 : 8'h01;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++)
                    b = b ^ gm(s[127-8*(j+4*c) -: 8], m[(j-r+4)%4]);
                o[127-8*(r+4*c) -: 8] = b;
            end
        return o;
    endfunction

    function automatic logic [127:0] dp(input logic [127:0] s, input logic [1:0] op,
                                        input logic dec, input logic [127:0] msg,
                                        input logic [127:0] rk);
        case (op)
            2'b00:   return msg;
            2'b01:   return s ^ rk;
            2'b10:   return dec ? mix(sub(shift(s, 1'b1), 1'b1) ^ rk, 1'b1)
                                : mix(shift(sub(s, 1'b0), 1'b0), 1'b0) ^ rk;
            default: return dec ? sub(shift(s, 1'b1), 1'b1) ^ rk
                                : shift(sub(s, 1'b0), 1'b0) ^ rk;
        endcase
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [2047:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [2047:0] o;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nk+7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]});
                t[31:24] = t[31:24] ^ rc;
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        o = '0;
        for (int k = 0; k < nk + 7; k++)
            o[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return o;
    endfunction

    always_ff @(posedge clk) begin
        if (ifa.state_en)
            st_a <= dp(st_a, ifa.op, ifa.mode_q, din_a, ks_a[128*ifa.round_idx +: 128]);
        if (ifb.state_en)
            st_b <= dp(st_b, ifb.op, ifb.mode_q, din_b, ks_b[128*ifb.round_idx +: 128]);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One block on the nr=10 controller; stall_at names the step (0=INIT,
    // r=ROUND r) whose first three cycles run with key_valid low, -1 = none.
    task automatic run_a(input logic md, input logic [127:0] msg, input logic [127:0] exp,
                         input int stall_at, input string tag);
        int step, stalls, ei, eo;
        ifa.mode = md; din_a = msg; ifa.start_valid = 1'b1; ifa.key_valid = 1'b1;
        #1;
        chk({tag, ":acc_ready"}, ifa.start_ready, 1);
        chk({tag, ":acc_en"}, ifa.state_en, 1);
        acc_cyc = cyc;
        @(negedge clk);
        ifa.mode = ~md;
        step = 0; stalls = 0;
        while (step <= 10) begin
            ifa.key_valid = !(step == stall_at && stalls < 3);
            #1;
            ei = md ? 10 - step : step;
            eo = (step == 0) ? 1 : (step == 10) ? 3 : 2;
            chk($sformatf("%s:idx%0d", tag, step), ifa.round_idx, ei);
            chk($sformatf("%s:op%0d", tag, step), ifa.op, eo);
            chk($sformatf("%s:en%0d", tag, step), ifa.state_en, ifa.key_valid);
            if (step == 0) chk({tag, ":mode_q"}, ifa.mode_q, md);
            if (ifa.key_valid) step++;
            else               stalls++;
            @(negedge clk);
        end
        ifa.start_valid = 1'b0; ifa.key_valid = 1'b1;
        #1;
        chk({tag, ":ovalid"}, ifa.out_valid, 1);
        chk({tag, ":data"}, st_a, exp);
        chk({tag, ":latency"}, cyc - acc_cyc, 12 + stalls);
    endtask

    task automatic finish_a(input int hold, input logic [127:0] exp, input string tag);
        ifa.out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            ifa.start_valid = 1'b1;
            @(negedge clk); #1;
            chk($sformatf("%s:hold_ov%0d", tag, i), ifa.out_valid, 1);
            chk($sformatf("%s:hold_dat%0d", tag, i), st_a, exp);
            chk($sformatf("%s:hold_rdy%0d", tag, i), ifa.start_ready, 0);
        end
        ifa.start_valid = 1'b0;
        ifa.out_ready = 1'b1;
        @(negedge clk);
        ifa.out_ready = 1'b0;
        #1;
        chk({tag, ":idle_ov"}, ifa.out_valid, 0);
        chk({tag, ":idle_busy"}, ifa.busy, 0);
        chk({tag, ":idle_rdy"}, ifa.start_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        ifa.key_valid = 1'b0; ifa.start_valid = 1'b0; ifa.mode = 1'b0; ifa.out_ready = 1'b0;
        ifb.key_valid = 1'b0; ifb.start_valid = 1'b0; ifb.mode = 1'b0; ifb.out_ready = 1'b0;
        din_a = '0; din_b = '0;
        for (int x = 0; x < 256; x++) begin
            iv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            bx = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]}
                    ^ {iv[3:0], iv[7:4]} ^ 8'h63;
            sb[x]   = bx;
            isb[bx] = 8'(x);
        end
        ks_a = expand(K128, 4);
        ks_b = expand(K256, 8);

        repeat (2) @(negedge clk);
        #1;
        chk("rst:op", ifa.op, 0);
        chk("rst:idx", ifa.round_idx, 0);
        chk("rst:en", ifa.state_en, 0);
        chk("rst:ov", ifa.out_valid, 0);
        chk("rst:busy", ifa.busy, 0);
        chk("rst:mode_q", ifa.mode_q, 0);

        // Request with the key schedule not ready must not be taken.
        rst_n = 1'b1; ifa.start_valid = 1'b1;
        #1;
        chk("nokey:rdy", ifa.start_ready, 0);
        chk("nokey:en", ifa.state_en, 0);
        @(negedge clk); #1;
        chk("nokey:busy", ifa.busy, 0);
        chk("nokey:op", ifa.op, 0);

        run_a(1'b0, PT, CT128, -1, "enc");
        finish_a(0, CT128, "enc");
        run_a(1'b1, CT128, PT, -1, "dec");
        finish_a(5, PT, "bp");

        prev_acc = acc_cyc;
        run_a(1'b0, PT, CT128, -1, "b2b1");
        prev_acc = acc_cyc;
        finish_a(0, CT128, "b2b1");
        run_a(1'b1, CT128, PT, -1, "b2b2");
        chk("b2b:spacing", acc_cyc - prev_acc, 13);
        finish_a(0, PT, "b2b2");

        run_a(1'b1, CT128, PT, 4, "stall");
        finish_a(0, PT, "stall");

        // Abort at ROUND r=6 of a decrypt.
        ifa.mode = 1'b1; din_a = CT128; ifa.start_valid = 1'b1; ifa.key_valid = 1'b1;
        @(negedge clk);
        ifa.start_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("abort:idx_r6", ifa.round_idx, 4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort:op", ifa.op, 0);
        chk("abort:idx", ifa.round_idx, 0);
        chk("abort:en", ifa.state_en, 0);
        chk("abort:ov", ifa.out_valid, 0);
        chk("abort:busy", ifa.busy, 0);
        chk("abort:mode_q", ifa.mode_q, 0);
        chk("abort:rdy", ifa.start_ready, 1);
        saw_ov = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk); #1;
            if (ifa.out_valid !== 1'b0) saw_ov = 1'b1;
        end
        chk("abort:no_ov", saw_ov, 0);
        run_a(1'b1, CT128, PT, -1, "fresh");
        finish_a(0, PT, "fresh");

        // AES-256 encrypt on the nr=14 controller.
        ifb.mode = 1'b0; din_b = PT; ifb.start_valid = 1'b1; ifb.key_valid = 1'b1;
        #1;
        chk("a256:acc_ready", ifb.start_ready, 1);
        acc_cyc = cyc;
        @(negedge clk);
        ifb.start_valid = 1'b0;
        for (int s = 0; s <= 14; s++) begin
            #1;
            chk($sformatf("a256:idx%0d", s), ifb.round_idx, s);
            @(negedge clk);
        end
        #1;
        chk("a256:ov", ifb.out_valid, 1);
        chk("a256:data", st_b, CT256);
        chk("a256:latency", cyc - acc_cyc, 16);
        ifb.out_ready = 1'b1;
        @(negedge clk);
        ifb.out_ready = 1'b0;
        #1;
        chk("a256:idle_ov", ifb.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
